// File: rtl/fir_xif_offloader.sv
// Core-side CV-X-IF initiator for the FIR coprocessor: encodes FIR commands, drives issue/commit,
// tracks writeback IDs that are still owed a result, and forwards matching results as responses.
//
// state  | meaning
// IDLE   | waiting for a command; ready when the next ID is free and below the outstanding limit
// ISSUE  | issue request held stable until the coprocessor takes it
// COMMIT | one-cycle commit strobe for the issued ID, then advance next_id
module fir_xif_offloader #(
    parameter int X_ID_WIDTH      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   cmd_valid_i,
    output logic                                   cmd_ready_o,
    input  logic [1:0]                             cmd_instr_i,
    input  logic [4:0]                             cmd_rs1_i,
    input  logic [4:0]                             cmd_rs2_i,
    input  logic [4:0]                             cmd_rd_i,
    input  logic [11:0]                            cmd_imm_i,
    input  logic [31:0]                            cmd_op_a_i,
    input  logic [31:0]                            cmd_op_b_i,
    input  logic                                   cmd_kill_i,
    output logic                                   x_issue_valid_o,
    input  logic                                   x_issue_ready_i,
    output logic [31:0]                            x_issue_instr_o,
    output logic [X_ID_WIDTH-1:0]                  x_issue_id_o,
    output logic [31:0]                            x_issue_rs0_o,
    output logic [31:0]                            x_issue_rs1_o,
    output logic [1:0]                             x_issue_rs_valid_o,
    input  logic                                   x_issue_accept_i,
    input  logic                                   x_issue_writeback_i,
    output logic                                   x_commit_valid_o,
    output logic [X_ID_WIDTH-1:0]                  x_commit_id_o,
    output logic                                   x_commit_kill_o,
    input  logic                                   x_result_valid_i,
    output logic                                   x_result_ready_o,
    input  logic [X_ID_WIDTH-1:0]                  x_result_id_i,
    input  logic [31:0]                            x_result_data_i,
    input  logic [4:0]                             x_result_rd_i,
    input  logic                                   x_result_we_i,
    output logic                                   rsp_valid_o,
    output logic [X_ID_WIDTH-1:0]                  rsp_id_o,
    output logic [4:0]                             rsp_rd_o,
    output logic [31:0]                            rsp_data_o,
    output logic                                   reject_o,
    output logic                                   spurious_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);
    localparam int              NID    = 2**X_ID_WIDTH;
    localparam int              OW     = $clog2(MAX_OUTSTANDING+1);
    localparam logic [6:0]      OPCODE = 7'b1011011;
    localparam logic [OW-1:0]   MAX_OS = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} state_e;

    state_e                 state_q;
    logic [X_ID_WIDTH-1:0]  next_id_q, id_q, commit_id_q, rsp_id_q;
    logic [31:0]            instr_q, rs0_q, rs1_q, rsp_data_q;
    logic [1:0]             rs_valid_q;
    logic                   kill_q, issue_valid_q, commit_valid_q, commit_kill_q;
    logic                   rsp_valid_q, reject_q, spurious_q;
    logic [4:0]             rsp_rd_q;
    logic [NID-1:0]         pending_q, pending_d, pend_set, pend_clr;
    logic [OW-1:0]          outstanding_q, outstanding_d;
    logic                   cmd_hs, res_hit;
    logic [31:0]            enc_instr;
    logic [1:0]             enc_rsv;

    // Ready terms are combinational, so gate them with reset to keep outputs low while held.
    assign cmd_ready_o      = rst_ni && (state_q == IDLE) && !pending_q[next_id_q]
                              && (outstanding_q < MAX_OS);
    assign x_result_ready_o = rst_ni;
    assign cmd_hs           = cmd_valid_i && cmd_ready_o;
    assign res_hit          = x_result_valid_i && pending_q[x_result_id_i];

    always_comb begin
        enc_rsv = 2'b11;
        case (cmd_instr_i)
            2'b10: begin
                enc_instr = {cmd_imm_i, cmd_rs1_i, 3'b000, cmd_rd_i, OPCODE};
                enc_rsv   = 2'b01;
            end
            2'b11:   enc_instr = {cmd_imm_i[11:5], cmd_rs2_i, cmd_rs1_i, 3'b001, cmd_imm_i[4:0], OPCODE};
            2'b01:   enc_instr = {7'b0, cmd_rs2_i, cmd_rs1_i, 3'b010, cmd_rd_i, OPCODE};
            default: enc_instr = {7'b0, cmd_rs2_i, cmd_rs1_i, 3'b111, cmd_rd_i, OPCODE};
        endcase
    end

    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (issue_valid_q && x_issue_ready_i && x_issue_accept_i && x_issue_writeback_i && !kill_q)
            pend_set[id_q] = 1'b1;
        if (res_hit)
            pend_clr[x_result_id_i] = 1'b1;
        pending_d     = (pending_q & ~pend_clr) | pend_set;
        outstanding_d = '0;
        for (int i = 0; i < NID; i++)
            outstanding_d = outstanding_d + OW'(pending_d[i]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            next_id_q      <= '0;
            id_q           <= '0;
            instr_q        <= '0;
            rs0_q          <= '0;
            rs1_q          <= '0;
            rs_valid_q     <= '0;
            kill_q         <= 1'b0;
            issue_valid_q  <= 1'b0;
            commit_valid_q <= 1'b0;
            commit_id_q    <= '0;
            commit_kill_q  <= 1'b0;
            reject_q       <= 1'b0;
        end else begin
            reject_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_hs) begin
                        instr_q       <= enc_instr;
                        rs0_q         <= cmd_op_a_i;
                        rs1_q         <= cmd_op_b_i;
                        rs_valid_q    <= enc_rsv;
                        kill_q        <= cmd_kill_i;
                        id_q          <= next_id_q;
                        issue_valid_q <= 1'b1;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (x_issue_ready_i) begin
                        issue_valid_q  <= 1'b0;
                        commit_valid_q <= 1'b1;
                        commit_id_q    <= id_q;
                        commit_kill_q  <= kill_q | !x_issue_accept_i;
                        reject_q       <= !x_issue_accept_i;
                        state_q        <= COMMIT;
                    end
                end
                COMMIT: begin
                    commit_valid_q <= 1'b0;
                    commit_kill_q  <= 1'b0;
                    next_id_q      <= next_id_q + X_ID_WIDTH'(1);
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_rd_q      <= '0;
            rsp_data_q    <= '0;
            spurious_q    <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            rsp_valid_q   <= res_hit;
            spurious_q    <= x_result_valid_i && !pending_q[x_result_id_i];
            if (res_hit) begin
                rsp_id_q   <= x_result_id_i;
                rsp_rd_q   <= x_result_rd_i;
                rsp_data_q <= x_result_we_i ? x_result_data_i : 32'h0;
            end
        end
    end

    assign x_issue_valid_o    = issue_valid_q;
    assign x_issue_instr_o    = instr_q;
    assign x_issue_id_o       = id_q;
    assign x_issue_rs0_o      = rs0_q;
    assign x_issue_rs1_o      = rs1_q;
    assign x_issue_rs_valid_o = rs_valid_q;
    assign x_commit_valid_o   = commit_valid_q;
    assign x_commit_id_o      = commit_id_q;
    assign x_commit_kill_o    = commit_kill_q;
    assign rsp_valid_o        = rsp_valid_q;
    assign rsp_id_o           = rsp_id_q;
    assign rsp_rd_o           = rsp_rd_q;
    assign rsp_data_o         = rsp_data_q;
    assign reject_o           = reject_q;
    assign spurious_o         = spurious_q;
    assign outstanding_o      = outstanding_q;
endmodule
